// File: rtl/pc_fetch_unit.sv
// Purpose: holds the PC, fetches each instruction over imem req/ack, issues it to decode, applies redirects, halts on faults.
// Latency: 1 cycle FETCH (ack in the first request cycle) + 1 cycle ISSUE = 2 cycles per instruction minimum.
// Backpressure: imem wait states hold FETCH up to TIMEOUT cycles; stall holds ISSUE with all state frozen.
//
// Ports:
//   clk, rst_n                   clock and async active-low reset
//   pc_o / pc_plus4_i            current PC out to the external adder, adder sum back in
//   imem_req/addr/ack/rdata      instruction memory handshake
//   instr_o / instr_valid        instruction presented to decode, valid in ISSUE
//   stall, jump(+target), branch_taken(+target)   control from the core
//   fetch_err                    sticky fault flag (timeout or misaligned PC)
//   instr_count                  retired-instruction counter (wraps at 2^32)
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    input  logic [31:0] pc_plus4_i,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_o,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        fetch_err,
    output logic [31:0] instr_count
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Last wait count before the fetch is declared dead.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] tmo_cnt;
    logic [31:0] next_pc;

    // Redirect selection: jump beats branch, otherwise fall through to PC+4.
    always_comb begin
        next_pc = pc_plus4_i;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    // The reset state is FETCH, but no request may be visible while reset is
    // held, so the request is qualified with rst_n.
    assign imem_req    = rst_n && (state == ST_FETCH);
    assign imem_addr   = pc_o;
    assign instr_valid = (state == ST_ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            pc_o        <= RESET_VECTOR;
            instr_o     <= 32'd0;
            fetch_err   <= 1'b0;
            instr_count <= 32'd0;
            tmo_cnt     <= 16'd0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_o <= imem_rdata;
                        tmo_cnt <= 16'd0;
                        state   <= ST_ISSUE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        fetch_err <= 1'b1;
                        state     <= ST_HALT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        instr_count <= instr_count + 32'd1;
                        pc_o        <= next_pc;
                        // A misaligned target is still loaded so the faulting
                        // address is visible on pc_o after the halt.
                        if (next_pc[1:0] != 2'b00) begin
                            fetch_err <= 1'b1;
                            state     <= ST_HALT;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_i;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr_o;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        fetch_err;
    logic [31:0] instr_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic [31:0] exp_count = 32'd0;
    logic [31:0] last_instr = 32'd0;

    always #5 clk = ~clk;

    // External PC+4 adder, modulo 2^32.
    assign pc_plus4_i = pc_o + 32'd4;

    pc_fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .TIMEOUT     (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_o         (pc_o),
        .pc_plus4_i   (pc_plus4_i),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_o      (instr_o),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .fetch_err    (fetch_err),
        .instr_count  (instr_count)
    );

    // Memory responder: called at a negedge in FETCH, waits then acks once.
    // The expected {address, word} pair is queued as the ack is driven.
    task mem_respond(input logic [31:0] data, input int waits);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
        end
        exp_q.push_back({imem_addr, data});
        imem_ack   = 1'b1;
        imem_rdata = data;
        last_instr = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    // Retire the instruction in ISSUE with the given redirect inputs.
    task retire(input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt);
        stall = 1'b0;
        jump = j; jump_target = jt;
        branch_taken = b; branch_target = bt;
        @(negedge clk);
        exp_count = exp_count + 32'd1;
        jump = 1'b0;
        branch_taken = 1'b0;
    endtask

    task test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({pc_o, imem_req, instr_valid, fetch_err, instr_count, instr_o} !== {32'd0, 3'b000, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_state: pc=%h req=%b valid=%b err=%b cnt=%h instr=%h, required all zero",
                     pc_o, imem_req, instr_valid, fetch_err, instr_count, instr_o);
        end
        rst_n = 1'b1;
        exp_count = 32'd0;
        #1;
    endtask

    task test_sequential;
        mem_respond(32'h2008_0001, 0);
        e = exp_q.pop_front(); n_cmp++;
        if (instr_valid !== 1'b1 || instr_o !== e[31:0] || pc_o !== e[63:32]) begin
            n_err++;
            $display("FAIL seq_issue0: valid=%b instr=%h pc=%h, required 1 %h %h", instr_valid, instr_o, pc_o, e[31:0], e[63:32]);
        end
        retire(1'b0, 32'd0, 1'b0, 32'd0);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL seq_addr1: req=%b addr=%h valid=%b, required 1 00000004 0", imem_req, imem_addr, instr_valid);
        end
        mem_respond(32'h2009_0002, 0);
        e = exp_q.pop_front(); n_cmp++;
        if (instr_valid !== 1'b1 || instr_o !== e[31:0] || pc_o !== e[63:32]) begin
            n_err++;
            $display("FAIL seq_issue1: valid=%b instr=%h pc=%h, required 1 %h %h", instr_valid, instr_o, pc_o, e[31:0], e[63:32]);
        end
        retire(1'b0, 32'd0, 1'b0, 32'd0);
        n_cmp++;
        if (instr_count !== 32'd2 || pc_o !== 32'h8) begin
            n_err++;
            $display("FAIL seq_end: cnt=%h pc=%h, required 2 00000008", instr_count, pc_o);
        end
    endtask

    task test_wait_states;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_o !== 32'h2009_0002 || fetch_err !== 1'b0) begin
                n_err++;
                $display("FAIL wait_hold[%0d]: req=%b addr=%h instr=%h err=%b, required 1 00000008 20090002 0",
                         i, imem_req, imem_addr, instr_o, fetch_err);
            end
            imem_ack = 1'b0;
            @(negedge clk);
        end
        mem_respond(32'h0000_00A0, 0);
        e = exp_q.pop_front(); n_cmp++;
        if (instr_valid !== 1'b1 || instr_o !== e[31:0] || pc_o !== e[63:32] || fetch_err !== 1'b0) begin
            n_err++;
            $display("FAIL wait_issue: valid=%b instr=%h pc=%h err=%b, required 1 %h %h 0",
                     instr_valid, instr_o, pc_o, fetch_err, e[31:0], e[63:32]);
        end
        retire(1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task test_redirect;
        mem_respond(32'h0000_1111, 0);
        void'(exp_q.pop_front());
        retire(1'b0, 32'd0, 1'b0, 32'd0);
        mem_respond(32'h0000_2222, 0);
        e = exp_q.pop_front(); n_cmp++;
        if (instr_valid !== 1'b1 || instr_o !== e[31:0] || pc_o !== 32'h10) begin
            n_err++;
            $display("FAIL redir_issue: valid=%b instr=%h pc=%h, required 1 %h 00000010", instr_valid, instr_o, pc_o, e[31:0]);
        end
        retire(1'b1, 32'h100, 1'b1, 32'h40);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_err++;
            $display("FAIL redir_jump: req=%b addr=%h, required 1 00000100", imem_req, imem_addr);
        end
        mem_respond(32'h0000_3333, 0);
        void'(exp_q.pop_front());
        retire(1'b0, 32'd0, 1'b1, 32'h40);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_err++;
            $display("FAIL redir_branch: req=%b addr=%h, required 1 00000040", imem_req, imem_addr);
        end
    endtask

    task test_stall;
        mem_respond(32'hDEAD_BEEF, 0);
        e = exp_q.pop_front(); n_cmp++;
        if (instr_valid !== 1'b1 || instr_o !== e[31:0] || pc_o !== e[63:32]) begin
            n_err++;
            $display("FAIL stall_issue: valid=%b instr=%h pc=%h, required 1 %h %h", instr_valid, instr_o, pc_o, e[31:0], e[63:32]);
        end
        // Redirects presented during a stall must have no effect.
        stall = 1'b1; jump = 1'b1; jump_target = 32'h300;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (instr_valid !== 1'b1 || pc_o !== 32'h40 || instr_o !== 32'hDEAD_BEEF || instr_count !== exp_count) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h cnt=%h, required 1 00000040 deadbeef %h",
                         i, instr_valid, pc_o, instr_o, instr_count, exp_count);
            end
        end
        jump = 1'b0;
        retire(1'b0, 32'd0, 1'b0, 32'd0);
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h44 || instr_count !== exp_count) begin
            n_err++;
            $display("FAIL stall_retire: valid=%b req=%b addr=%h cnt=%h, required 0 1 00000044 %h",
                     instr_valid, imem_req, imem_addr, instr_count, exp_count);
        end
    endtask

    task test_reset_midfetch;
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pc_o !== 32'd0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || instr_count !== 32'd0) begin
            n_err++;
            $display("FAIL rst_midfetch: pc=%h req=%b valid=%b err=%b cnt=%h, required 0 0 0 0 0",
                     pc_o, imem_req, instr_valid, fetch_err, instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 32'd0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            n_err++;
            $display("FAIL rst_refetch: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
        end
    endtask

    task test_wrap;
        mem_respond(32'h0000_0013, 0);
        void'(exp_q.pop_front());
        stall = 1'b1;
        force dut.instr_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.instr_count;
        exp_count = 32'hFFFF_FFFF;
        retire(1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        n_cmp++;
        if (instr_count !== exp_count || instr_count !== 32'd0 || imem_addr !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_count: cnt=%h addr=%h, required 00000000 fffffffc", instr_count, imem_addr);
        end
        mem_respond(32'h0000_0013, 0);
        e = exp_q.pop_front(); n_cmp++;
        if (instr_valid !== 1'b1 || pc_o !== e[63:32] || pc_o !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_issue: valid=%b pc=%h, required 1 fffffffc", instr_valid, pc_o);
        end
        retire(1'b0, 32'd0, 1'b0, 32'd0);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || fetch_err !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_pc: req=%b addr=%h err=%b, required 1 00000000 0", imem_req, imem_addr, fetch_err);
        end
    endtask

    task test_misaligned;
        mem_respond(32'h0000_0013, 0);
        void'(exp_q.pop_front());
        retire(1'b1, 32'h0000_0102, 1'b0, 32'd0);
        n_cmp++;
        if (fetch_err !== 1'b1 || pc_o !== 32'h102 || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_count !== exp_count) begin
            n_err++;
            $display("FAIL misalign: err=%b pc=%h req=%b valid=%b cnt=%h, required 1 00000102 0 0 %h",
                     fetch_err, pc_o, imem_req, instr_valid, instr_count, exp_count);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (fetch_err !== 1'b1 || pc_o !== 32'h102 || imem_req !== 1'b0 || instr_valid !== 1'b0
            || instr_o !== 32'h0000_0013 || instr_count !== exp_count) begin
            n_err++;
            $display("FAIL halt_frozen: err=%b pc=%h req=%b valid=%b instr=%h cnt=%h, required 1 00000102 0 0 00000013 %h",
                     fetch_err, pc_o, imem_req, instr_valid, instr_o, instr_count, exp_count);
        end
        imem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (fetch_err !== 1'b0 || pc_o !== 32'd0) begin
            n_err++;
            $display("FAIL rst_clears_err: err=%b pc=%h, required 0 00000000", fetch_err, pc_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 32'd0;
        #1;
    endtask

    task test_timeout;
        imem_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
                n_err++;
                $display("FAIL tmo_wait[%0d]: req=%b err=%b, required 1 0", i, imem_req, fetch_err);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_fault: err=%b req=%b valid=%b, required 1 0 0", fetch_err, imem_req, instr_valid);
        end
        // Late acks arriving in HALT must be ignored.
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_o !== 32'd0 || pc_o !== 32'd0) begin
            n_err++;
            $display("FAIL tmo_halt: err=%b req=%b valid=%b instr=%h pc=%h, required 1 0 0 00000000 00000000",
                     fetch_err, imem_req, instr_valid, instr_o, pc_o);
        end
        imem_ack = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_wait_states;
        test_redirect;
        test_stall;
        test_reset_midfetch;
        test_wrap;
        test_misaligned;
        test_timeout;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer for the single-cycle core. Holds the current PC and drives it as operand `a` into the PC+4 adder (`b` = 32'd4), then consumes the adder's sum as the sequential next PC. Fetches each instruction from instruction memory over a req/ack handshake and presents it to decode with a valid strobe. Applies jump/branch redirects and stalls, and halts on a fetch fault.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, maximum cycles FETCH waits for imem_ack before faulting; 1..65535.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_o  out  32  current PC; wired to adder input a
pc_plus4_i  in  32  adder sum (pc_o + 4)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word
instr_o  out  32  latched instruction to decode
instr_valid  out  1  instr_o valid; core executes it this cycle
stall  in  1  hold current instruction in ISSUE
jump  in  1  take jump_target
jump_target  in  32  jump destination
branch_taken  in  1  take branch_target
branch_target  in  32  branch destination
fetch_err  out  1  sticky fault flag
instr_count  out  32  retired-instruction counter

Behaviour:
- Async reset (rst_n low, any cycle):
  - pc_o=RESET_VECTOR; state=FETCH; imem_req=0; instr_o=0; instr_valid=0; fetch_err=0; instr_count=0; timeout counter=0.
  - Reset mid-fetch abandons the request; no retire occurs.
- States: FETCH, ISSUE, HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc_o (combinational from state).
  - On imem_ack: instr_o<=imem_rdata, clear timeout counter, go to ISSUE.
  - Ack in the first request cycle is legal, giving 1-cycle fetch latency.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1 without ack: fetch_err<=1, go to HALT.
  - An imem_ack outside FETCH is ignored.
- ISSUE:
  - instr_valid=1, imem_req=0.
  - stall=1: remain in ISSUE; pc_o, instr_o and instr_count unchanged. Redirect inputs are ignored.
  - stall=0: retire the instruction:
    - instr_count<=instr_count+1, wrapping at 2^32 (0xFFFFFFFF -> 0).
    - pc_o<= jump ? jump_target : branch_taken ? branch_target : pc_plus4_i. jump has priority when both are asserted.
    - Go to FETCH.
  - Misaligned next PC (selected value [1:0]!=0): fetch_err<=1, pc_o loaded anyway, go to HALT; instr_count still increments.
  - PC arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 -> 0x0000_0000, no fault.
- HALT:
  - imem_req=0, instr_valid=0; all registers frozen.
  - Exit only by reset.
- fetch_err is sticky until reset.
- Throughput: one instruction per 2 cycles minimum (FETCH+ack, then ISSUE).

Test Plan:
- Sequential fetch: release reset; memory acks immediately with 0x20080001, 0x20090002 -> imem_addr 0x0, then 0x4; instr_valid high on cycles 2 and 4; instr_count=2; pc_o=0x8.
- Wait states: ack delayed 3 cycles -> imem_req held 4 cycles at constant imem_addr; instr_o updates only on the ack cycle; no fault.
- Redirect priority: in ISSUE at pc 0x10 with jump=1 (0x100) and branch_taken=1 (0x40) -> next imem_addr=0x100. With branch only -> 0x40.
- Stall: stall=1 for 5 ISSUE cycles -> instr_valid high throughout; pc_o, instr_o and instr_count constant; retire on the first cycle with stall=0.
- Faults:
  - No ack for TIMEOUT=16 cycles -> fetch_err=1 and imem_req=0 from the next cycle; stays in HALT.
  - Separately, jump_target=0x102 -> fetch_err=1 and pc_o=0x102.
- Reset and wrap:
  - rst_n pulsed low mid-FETCH -> pc_o=RESET_VECTOR and fetch_err=0 immediately.
  - instr_count preloaded via force to 0xFFFFFFFF -> wraps to 0 on retire.
  - pc 0xFFFFFFFC -> next imem_addr 0x0.
